warp_imem_arbiter: RTL and testbench
====================================

// Module: warp_imem_arbiter
// PURPOSE
//  Shares one instruction-memory read port among NUM_HARTS warp_hart fetch ports.
//  Each hart sees the same imem handshake it drives today (ren/raddr out, valid/rdata in).
//  Round-robin grant, exactly one outstanding memory read at a time.
//  Sits between the hart array and the imem/icache port.
// PARAMETERS
//  NUM_HARTS  4   number of requesting harts (>=2)
//  ADDR_W     39  fetch address width (Sv39 VA)
//  DATA_W     64  fetch data width (two 32-bit instructions)
// PORTS
//  i_clk          in   1                  clock, all state on posedge
//  i_rst          in   1                  async reset, active-high
//  i_hart_ren     in   NUM_HARTS          per-hart fetch request, level, held until valid
//  i_hart_raddr   in   NUM_HARTS*ADDR_W   per-hart fetch address, hart h at [h*ADDR_W +: ADDR_W]
//  o_hart_valid   out  NUM_HARTS          per-hart response strobe, one-hot or zero
//  o_hart_rdata   out  DATA_W             response data, broadcast to all harts
//  o_mem_ren      out  1                  memory read strobe, one-cycle pulse
//  o_mem_raddr    out  ADDR_W             memory read address, registered
//  i_mem_valid    in   1                  memory response strobe
//  i_mem_rdata    in   DATA_W             memory response data
//  o_busy         out  1                  request outstanding (state == BUSY)
//  o_grant_id     out  $clog2(NUM_HARTS)  hart owning current/last request
// BEHAVIOUR
//  Reset (async): state=IDLE, o_mem_ren=0, o_mem_raddr=0, o_grant_id=0, o_busy=0,
//   last-grant pointer=NUM_HARTS-1, so hart 0 has top priority first. o_hart_valid=0.
//  FSM states: IDLE, ISSUE, BUSY.
//  IDLE: if any i_hart_ren, pick first set bit scanning from pointer+1 (wrapping).
//   At that edge, latch grant id and its address into o_grant_id/o_mem_raddr -> ISSUE.
//   No request: stay IDLE.
//  ISSUE: o_mem_ren=1 for exactly this cycle -> BUSY next edge. i_mem_valid ignored.
//  BUSY: o_mem_ren=0, o_mem_raddr held.
//   On i_mem_valid: o_hart_valid[o_grant_id]=i_mem_valid and o_hart_rdata=i_mem_rdata.
//   Both combinational, same cycle. Pointer<=o_grant_id, state -> IDLE.
//  o_hart_rdata = i_mem_rdata at all times; only o_hart_valid qualifies it.
//  Latency: request seen in IDLE at edge N -> o_mem_ren high in cycle N..N+1.
//   Response forwarded in the cycle memory returns it (min. one cycle after ren).
//   Back-to-back grants: IDLE cycle, ISSUE cycle, >=1 BUSY cycle = 3-cycle minimum per fetch.
//  Hart rule: ren high in IDLE is a new request. A hart drops ren the cycle after its valid
//   unless it has a new fetch.
//  Withdrawal: ren dropped while granted has no effect. The read completes and valid still
//   pulses to that hart; the hart discards it.
//  Address changed while granted: ignored; latched address is used.
//  Spurious i_mem_valid in IDLE or ISSUE: ignored, no o_hart_valid, no state change.
//  Reset mid-operation: immediate IDLE. A late memory response after reset is ignored
//   (arrives in IDLE).
//  Simultaneous requests: strict round-robin. A continuously requesting hart waits at most
//   NUM_HARTS-1 grants.
// TESTING
//  1. Hart 2 ren, raddr 0x4000000000. Expect o_mem_ren 1-cycle pulse, raddr 0x4000000000,
//     grant_id 2. Memory valid 2 cycles later with 0x00100133_001000b3: o_hart_valid=4'b0100
//     for that cycle, rdata matches.
//  2. Post-reset, all 4 harts ren, memory latency 1. Expect grant order 0,1,2,3 and one
//     valid pulse each.
//  3. Harts 0 and 3 request continuously for 6 fetches -> grants alternate 0,3,0,3,0,3.
//  4. Hart 1 drops ren in BUSY. Expect valid still delivered to hart 1; next grant proceeds.
//  5. Assert i_rst during BUSY, then memory valid. Expect o_hart_valid=0, o_mem_ren=0,
//     state IDLE, hart 0 granted first afterwards.
//  6. i_mem_valid pulsed in IDLE and in ISSUE -> o_hart_valid stays 0, no state change.

Source files
------------

// File: rtl/warp_imem_arbiter.sv
// Round-robin arbiter that shares one instruction-memory read port among the
// hart fetch ports. Only one memory read is outstanding at any time.
//
// state | meaning
// IDLE  | no read outstanding, choose the next requester
// ISSUE | o_mem_ren pulses with the latched address
// BUSY  | wait for i_mem_valid, then forward it to the granted hart
module warp_imem_arbiter #(
  parameter int NUM_HARTS = 4,
  parameter int ADDR_W    = 39,
  parameter int DATA_W    = 64,
  localparam int GID_W    = $clog2(NUM_HARTS)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_HARTS-1:0]        i_hart_ren,
  input  logic [NUM_HARTS*ADDR_W-1:0] i_hart_raddr,
  output logic [NUM_HARTS-1:0]        o_hart_valid,
  output logic [DATA_W-1:0]           o_hart_rdata,
  output logic                        o_mem_ren,
  output logic [ADDR_W-1:0]           o_mem_raddr,
  input  logic                        i_mem_valid,
  input  logic [DATA_W-1:0]           i_mem_rdata,
  output logic                        o_busy,
  output logic [GID_W-1:0]            o_grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [GID_W-1:0] ptr, ptr_nxt;
  logic [GID_W-1:0] pick;
  logic             found;
  int               idx;

  // First requester after the last-granted hart, wrapping around.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_HARTS; i++) begin
      idx = (int'(ptr) + i) % NUM_HARTS;
      if (!found && i_hart_ren[idx]) begin
        pick  = idx[GID_W-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE:  if (found) state_nxt = ISSUE;
      ISSUE: state_nxt = BUSY;
      BUSY: begin
        if (i_mem_valid) begin
          state_nxt = IDLE;
          ptr_nxt   = o_grant_id;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      ptr         <= GID_W'(NUM_HARTS - 1);
      o_grant_id  <= '0;
      o_mem_raddr <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      // Address is captured once at grant; later changes by the hart are ignored.
      if (state == IDLE && found) begin
        o_grant_id  <= pick;
        o_mem_raddr <= i_hart_raddr[int'(pick)*ADDR_W +: ADDR_W];
      end
    end
  end

  assign o_mem_ren    = (state == ISSUE);
  assign o_busy       = (state == BUSY);
  assign o_hart_rdata = i_mem_rdata;

  // Responses outside BUSY are stale or spurious and are dropped.
  always_comb begin
    o_hart_valid = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      o_hart_valid[h] = (state == BUSY) && i_mem_valid && (o_grant_id == GID_W'(h));
    end
  end

endmodule

// File: tb/tb_warp_imem_arbiter.sv
// Bench for warp_imem_arbiter: table of fetch transactions plus hand-written
// reset and spurious-response sequences; a negedge monitor checks queued expectations.
module tb_warp_imem_arbiter;

  localparam int NH = 4;
  localparam int AW = 39;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NH-1:0]   hart_ren = '0;
  logic [NH*AW-1:0] hart_raddr;
  logic [NH-1:0]   hart_valid;
  logic [DW-1:0]   hart_rdata;
  logic            mem_ren;
  logic [AW-1:0]   mem_raddr;
  logic            mem_valid = 1'b0;
  logic [DW-1:0]   mem_rdata = '0;
  logic            busy;
  logic [1:0]      grant_id;

  logic [AW-1:0]   addr [NH];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rst_before;
    logic [NH-1:0] mask;
    logic [NH-1:0] busy_mask;
    logic          chg_addr;
    logic          spur_issue;
    int            lat;
    int            exp_g;
    logic [DW-1:0] data;
  } vec_t;

  typedef struct {
    int            g;
    logic [AW-1:0] a;
  } req_t;

  typedef struct {
    logic [NH-1:0] v;
    logic [DW-1:0] d;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  vec_t tbl [14];

  always #5 clk = ~clk;

  always_comb begin
    hart_raddr = '0;
    for (int h = 0; h < NH; h++) hart_raddr[h*AW +: AW] = addr[h];
  end

  warp_imem_arbiter #(.NUM_HARTS(NH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_hart_ren   (hart_ren),
    .i_hart_raddr (hart_raddr),
    .o_hart_valid (hart_valid),
    .o_hart_rdata (hart_rdata),
    .o_mem_ren    (mem_ren),
    .o_mem_raddr  (mem_raddr),
    .i_mem_valid  (mem_valid),
    .i_mem_rdata  (mem_rdata),
    .o_busy       (busy),
    .o_grant_id   (grant_id)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every memory request and every hart response must match the queue head.
  logic ren_prev = 1'b0;
  always @(negedge clk) begin
    req_t r;
    rsp_t s;
    if (rst) begin
      ren_prev = 1'b0;
    end else begin
      if (mem_ren) begin
        chk("mem_ren_single_cycle", 64'(ren_prev), 64'd0);
        if (req_q.size() == 0) begin
          chk("unexpected_mem_ren", 64'd1, 64'd0);
        end else begin
          r = req_q.pop_front();
          chk("grant_id", 64'(grant_id), 64'(r.g));
          chk("mem_raddr", 64'(mem_raddr), 64'(r.a));
        end
      end
      if (hart_valid != '0) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_hart_valid", 64'(hart_valid), 64'd0);
        end else begin
          s = rsp_q.pop_front();
          chk("hart_valid", 64'(hart_valid), 64'(s.v));
          chk("hart_rdata", hart_rdata, s.d);
        end
      end
      ren_prev = mem_ren;
    end
  end

  task automatic do_reset();
    rst       = 1'b1;
    hart_ren  = '0;
    mem_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mem_ren", 64'(mem_ren), 64'd0);
    chk("rst_mem_raddr", 64'(mem_raddr), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hart_valid", 64'(hart_valid), 64'd0);
  endtask

  // Drives one fetch starting in IDLE, at posedge+1; returns in IDLE at posedge+1.
  task automatic run_fetch(input vec_t v);
    int   n;
    req_t r;
    rsp_t s;
    if (v.rst_before) do_reset();
    hart_ren = v.mask;
    r.g = v.exp_g;
    r.a = addr[v.exp_g];
    req_q.push_back(r);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!mem_ren && n < 10);
    if (!mem_ren) begin
      chk("issue_timeout", 64'd0, 64'd1);
      req_q.delete();
      return;
    end
    if (v.chg_addr) addr[v.exp_g] = addr[v.exp_g] ^ 39'h1_0000_0f00;
    if (v.spur_issue) begin
      mem_valid = 1'b1;
      mem_rdata = 64'hdead_beef_0bad_f00d;
      #1;
      chk("spur_issue_valid", 64'(hart_valid), 64'd0);
    end
    for (int k = 0; k < v.lat; k++) begin
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
      if (k == 0) hart_ren = v.busy_mask;
      chk("busy_wait", 64'(busy), 64'd1);
    end
    s.v = '0;
    s.v[v.exp_g] = 1'b1;
    s.d = v.data;
    rsp_q.push_back(s);
    mem_valid = 1'b1;
    mem_rdata = v.data;
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    chk("idle_after_rsp", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    addr[0] = 39'h00_1000_0000;
    addr[1] = 39'h12_3456_7890;
    addr[2] = 39'h40_0000_0000;
    addr[3] = 39'h7f_ffff_fff8;

    //          rst   mask     busy_mask chg   spur  lat g  data
    tbl[0]  = '{1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 2, 2, 64'h00100133_001000b3};
    tbl[1]  = '{1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, 1, 0, 64'h1111_0000_0000_0001};
    tbl[2]  = '{1'b0, 4'b1110, 4'b1110, 1'b0, 1'b0, 1, 1, 64'h1111_0000_0000_0002};
    tbl[3]  = '{1'b0, 4'b1100, 4'b1100, 1'b0, 1'b0, 1, 2, 64'h1111_0000_0000_0003};
    tbl[4]  = '{1'b0, 4'b1000, 4'b1000, 1'b0, 1'b0, 1, 3, 64'h1111_0000_0000_0004};
    tbl[5]  = '{1'b0, 4'b1001, 4'b1001, 1'b0, 1'b0, 1, 0, 64'h3333_0000_0000_0000};
    tbl[6]  = '{1'b0, 4'b1001, 4'b1001, 1'b0, 1'b0, 2, 3, 64'h3333_0000_0000_0003};
    tbl[7]  = '{1'b0, 4'b1001, 4'b1001, 1'b1, 1'b0, 1, 0, 64'h3333_0000_0000_0010};
    tbl[8]  = '{1'b0, 4'b1001, 4'b1001, 1'b0, 1'b0, 3, 3, 64'h3333_0000_0000_0013};
    tbl[9]  = '{1'b0, 4'b1001, 4'b1001, 1'b0, 1'b0, 1, 0, 64'h3333_0000_0000_0020};
    tbl[10] = '{1'b0, 4'b1001, 4'b1001, 1'b0, 1'b0, 1, 3, 64'h3333_0000_0000_0023};
    tbl[11] = '{1'b0, 4'b0110, 4'b0100, 1'b1, 1'b0, 2, 1, 64'h4444_0000_0000_0001};
    tbl[12] = '{1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0, 1, 2, 64'h4444_0000_0000_0002};
    tbl[13] = '{1'b0, 4'b0001, 4'b0001, 1'b0, 1'b1, 2, 0, 64'h6666_0000_0000_0000};

    for (int i = 0; i < 14; i++) run_fetch(tbl[i]);

    // Spurious response while IDLE: nothing forwarded, no state change.
    hart_ren  = '0;
    mem_valid = 1'b1;
    mem_rdata = 64'h0bad_0bad_0bad_0bad;
    #1;
    chk("spur_idle_valid", 64'(hart_valid), 64'd0);
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    chk("spur_idle_busy", 64'(busy), 64'd0);
    chk("spur_idle_ren", 64'(mem_ren), 64'd0);

    // Reset while BUSY, then a late response.
    hart_ren = 4'b1000;
    begin
      req_t r;
      r.g = 3;
      r.a = addr[3];
      req_q.push_back(r);
    end
    @(posedge clk);
    #1;
    chk("rst5_issue", 64'(mem_ren), 64'd1);
    @(posedge clk);
    #1;
    chk("rst5_busy", 64'(busy), 64'd1);
    hart_ren = '0;
    rst = 1'b1;
    #1;
    chk("rst5_busy_cleared", 64'(busy), 64'd0);
    chk("rst5_mem_ren", 64'(mem_ren), 64'd0);
    chk("rst5_grant", 64'(grant_id), 64'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_valid = 1'b1;
    mem_rdata = 64'h5555_5555_5555_5555;
    #1;
    chk("rst5_late_valid", 64'(hart_valid), 64'd0);
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    chk("rst5_late_busy", 64'(busy), 64'd0);
    chk("rst5_late_ren", 64'(mem_ren), 64'd0);

    v = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 1, 0, 64'h5a5a_0000_0000_0000};
    run_fetch(v);

    hart_ren = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("req_q_drained", 64'(req_q.size()), 64'd0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
